// File: rtl/product_encoder.sv
// product_encoder: 8x8 slid product-code encoder, one row per clock; ENCODER_DEBUG_EN enables trace prints
module product_encoder #(
  parameter int SLIDE_STEP = 1,
  parameter int TOP_ROWS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  info_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] codeword,
  output logic         busy,
  input  logic         debug_mode
);
  typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;
  state_t state;
  logic [63:0] info;
  logic [2:0] row_cnt, k;
  logic [7:0] row, slid, row_par, top_par, bot_par, row_par_n, top_par_n, bot_par_n;
  logic [15:0] dbl;
  logic top;
  always_comb begin
    row = info[{~row_cnt, 3'b000} +: 8];
    k = 3'(int'(row_cnt) * SLIDE_STEP);
    dbl = {row, row} << k;
    slid = dbl[15:8];
    top = int'(row_cnt) < TOP_ROWS;
    row_par_n = row_par;
    row_par_n[~row_cnt] = ^row;
    top_par_n = top ? top_par ^ slid : top_par;
    bot_par_n = top ? bot_par : bot_par ^ slid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      codeword <= '0;
      info <= '0;
      row_cnt <= '0;
      row_par <= '0;
      top_par <= '0;
      bot_par <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          info <= info_bits;
          row_cnt <= '0;
          row_par <= '0;
          top_par <= '0;
          bot_par <= '0;
          in_ready <= 1'b0;
          busy <= 1'b1;
          state <= ENCODE;
        end
        ENCODE: begin
          row_par <= row_par_n;
          top_par <= top_par_n;
          bot_par <= bot_par_n;
          row_cnt <= row_cnt + 3'd1;
          if (row_cnt == 3'd7) begin
            codeword <= {info, row_par_n, top_par_n, bot_par_n, 40'h0};
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ENCODER_DEBUG_EN
  always @(posedge clk) begin
    if (!rst && debug_mode) begin
      if (state == IDLE && in_valid && in_ready) $display("#ENCODER# accept %h", info_bits);
      if (state == ENCODE) $display("#ENCODER# r=%0d slid=%h par=%b", row_cnt, slid, ^row);
      if (state == ENCODE && row_cnt == 3'd7) $display("#ENCODER# codeword %h", {info, row_par_n, top_par_n, bot_par_n, 40'h0});
    end
  end
`else
  logic unused_debug;
  assign unused_debug = debug_mode;
`endif
endmodule

// File: tb/tb_product_encoder.sv
// tb_product_encoder: randomized and directed checks of product_encoder against a bitwise table model
module tb_product_encoder;
  localparam int SLIDE = 1;
  localparam int TOP = 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, debug_mode = 0;
  logic in_ready, out_valid, busy;
  logic [63:0] info_bits = '0;
  logic [127:0] codeword, cw;
  int n_cmp = 0, n_err = 0;
  product_encoder #(.SLIDE_STEP(SLIDE), .TOP_ROWS(TOP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .info_bits(info_bits),
    .out_valid(out_valid), .out_ready(out_ready), .codeword(codeword), .busy(busy),
    .debug_mode(debug_mode)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] model(input logic [63:0] w);
    logic [7:0] rp, tp, bp;
    rp = '0; tp = '0; bp = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rp[7-r] ^= w[63-8*r-c];
        if (r < TOP) tp[7-c] ^= w[63-8*r-((c+r*SLIDE)%8)];
        else bp[7-c] ^= w[63-8*r-((c+r*SLIDE)%8)];
      end
    return {w, rp, tp, bp, 40'h0};
  endfunction
  task automatic accept(input logic [63:0] w);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready", in_ready, 1);
    in_valid = 1; info_bits = w;
    @(posedge clk); #1;
    in_valid = 0; info_bits = {$urandom, $urandom};
  endtask
  task automatic run(input logic [63:0] w, input int stall, input bit poke, output logic [127:0] res);
    int n = 0;
    accept(w);
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, 8);
    chk("codeword", codeword, model(w));
    chk("busy_done", {busy, in_ready}, 2'b10);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin in_valid = 1; info_bits = ~w; end
      @(posedge clk); #1;
      in_valid = 0;
      chk("hold", {out_valid, in_ready, codeword}, {2'b10, model(w)});
    end
    res = codeword;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("taken", {out_valid, in_ready, busy}, 3'b010);
    chk("cw_kept", codeword, res);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_state", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_cw", codeword, 0);
    run(64'h0, 0, 0, cw);
    chk("t1", cw, 0);
    run(64'h8000_0000_0000_0000, 0, 0, cw);
    chk("t2", cw[63:40], 24'h808000);
    run(64'h0000_0000_0000_0080, 1, 0, cw);
    chk("t3", cw[63:40], 24'h010040);
    run(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, cw);
    chk("t4", cw, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    run(64'h0123_4567_89AB_CDEF, 5, 1, cw);
    accept(64'hDEAD_BEEF_0BAD_F00D);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("t6_rst", {in_ready, out_valid, busy, codeword}, {3'b100, 128'h0});
    run(64'h8000_0000_0000_0000, 0, 0, cw);
    chk("t6", cw[63:40], 24'h808000);
    for (int i = 0; i < 40; i++) run({$urandom, $urandom}, int'($urandom_range(0, 3)), 1'($urandom), cw);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
